fp_align_sequencer: RTL and testbench
=====================================

# fp_align_sequencer

Upstream alignment stage of the FP adder/subtractor: accepts two packed operands, orders them by magnitude, computes the exponent difference, and drives the mantissa shift register to right-shift the smaller mantissa. It then presents aligned mantissas, the common exponent and a sticky bit to the add/subtract core. Zero-difference and out-of-range differences bypass the shifter.

## Interface
- Mantissa_Size, 23, stored fraction bits M; internal mantissas are M+1 bits with the hidden bit.
- Exponent_Size, 8, biased exponent bits E; operand width is 1+E+M.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**.
- start  in  1  request; accepted only in IDLE.
- a, b  in  E+M+1  packed operands {sign, exponent, fraction}.
- busy  out  1  high in every state except IDLE.
- valid  out  1  one-cycle pulse; result outputs are valid from this cycle.
- big_sign, small_sign  out  1  signs of larger/smaller-magnitude operand.
- exp_out  out  E  exponent of larger operand.
- big_mant  out  M+1  larger mantissa with hidden bit.
- small_mant  out  M+1  smaller mantissa after right shift by diff.
- sticky  out  1  OR of all bits shifted out of small_mant.
- swapped  out  1  1 when b was the larger operand.
- err  out  1  shifter timeout occurred on this result.
- sh_enable, sh_load, sh_direction  out  1  shifter controls.
- sh_no_of_shifts  out  E  shift count to shifter.
- sh_unshifted  out  M+1  mantissa to shifter.
- sh_shifted  in  M+1  shifter result.
- sh_done  in  1  shifter completion flag.

## Operation
- Hidden bit = 1 if exponent ≠ 0, else 0 (denormal).
- Ordering: larger exponent wins; equal exponents → larger fraction wins; full tie → a is big, swapped=0.
- diff = exp_big − exp_small, unsigned E bits, never negative.
- States: IDLE, CMP, LOAD, SHIFT, DONE.
- IDLE: start=1 registers a, b → CMP. start during any other state is ignored.
- CMP: computes ordering, diff, sticky; registers big fields. diff=0 → DONE with small_mant = unshifted, sticky=0. diff ≥ M+1 → DONE with small_mant=0, sticky = OR of unshifted small mantissa. Otherwise → LOAD.
- sticky for 0<diff≤M: OR of the low diff bits of the unshifted small mantissa, computed in CMP.
- LOAD: sh_enable=1, sh_load=1, sh_unshifted = small mantissa, sh_no_of_shifts = diff → SHIFT.
- SHIFT: sh_enable=1, sh_load=0; sh_done is sampled only here. sh_done=1 → capture sh_shifted into small_mant → DONE. A watchdog counts SHIFT cycles; on reaching M+4 without sh_done → DONE with small_mant=0, sticky=1, err=1.
- DONE: valid=1 for one cycle → IDLE. Outputs hold until the next CMP update.
- sh_direction is constant 1 (right shift). sh_enable=0 in IDLE, CMP and DONE.
- err is cleared in CMP of the next operation.

## Timing
- Reset (asynchronous, any state): state=IDLE; busy, valid, err, sticky, swapped, sh_enable, sh_load = 0; sh_direction=1; all data outputs = 0. Reset during SHIFT abandons the operation with no valid pulse.
- Start sampled at edge 0. Bypass path: valid is high in the cycle after edge 1 (latency 2).
- Shift path with a compliant shifter: LOAD in cycle after edge 1; shifter loads at edge 2; valid is high in the cycle after edge 4+diff (latency diff+5).
- busy rises in the cycle after the accepting edge and falls together with valid.
- A new start is accepted in the first IDLE cycle after DONE, giving back-to-back throughput of one result per latency+1 cycles.

## Test plan
- M=23,E=8: a=0x40400000 (3.0), b=0x3F800000 (1.0) → diff=1, big_mant=0xC00000, small_mant=0x400000, sticky=0, swapped=0, valid 6 cycles after start.
- a=0x3F800000, b=0x41200000 (10.0) → swapped=1, exp_out=0x82, diff=3, small_mant=0x100000, sticky=0, big_sign=small_sign=0.
- a=0x4B800000, b=0x3F800001 → diff=24 ≥ M+1: bypass, small_mant=0, sticky=1, latency 2, sh_enable never asserted.
- Equal exponents, a=0x3F800000, b=0xBF800001 → swapped=1, big_sign=1, diff=0, bypass, sticky=0.
- Hold sh_done=0 throughout → err=1, small_mant=0, sticky=1, valid after M+4 SHIFT cycles; next operation clears err.
- Deassert rst_n during SHIFT → all outputs zero immediately, no valid; start after release completes normally. Start pulsed while busy → ignored, no second valid.

Source files
------------

// File: rtl/fp_align_sequencer.sv
`default_nettype none
// ============================================================================
// fp_align_sequencer : orders two FP operands by magnitude and right-aligns
// the smaller mantissa through an external shifter.  Rev 1.0
// ============================================================================
module fp_align_sequencer #(
  parameter int Mantissa_Size = 23,
  parameter int Exponent_Size = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [Exponent_Size+Mantissa_Size:0]   a,
  input  logic [Exponent_Size+Mantissa_Size:0]   b,
  output logic                                   busy,
  output logic                                   valid,
  output logic                                   big_sign,
  output logic                                   small_sign,
  output logic [Exponent_Size-1:0]               exp_out,
  output logic [Mantissa_Size:0]                 big_mant,
  output logic [Mantissa_Size:0]                 small_mant,
  output logic                                   sticky,
  output logic                                   swapped,
  output logic                                   err,
  output logic                                   sh_enable,
  output logic                                   sh_load,
  output logic                                   sh_direction,
  output logic [Exponent_Size-1:0]               sh_no_of_shifts,
  output logic [Mantissa_Size:0]                 sh_unshifted,
  input  logic [Mantissa_Size:0]                 sh_shifted,
  input  logic                                   sh_done
);

  localparam int M    = Mantissa_Size;
  localparam int E    = Exponent_Size;
  localparam int W    = 1 + E + M;
  localparam int MW   = M + 1;
  localparam int WD_W = $clog2(M + 4);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(M + 3);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMP   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]    a_reg, b_reg;
  logic [MW-1:0]   small_unsh;
  logic [E-1:0]    diff_reg;
  logic [WD_W-1:0] wd_cnt;

  logic            b_bigger;
  logic [W-1:0]    big_op, small_op;
  logic [E-1:0]    big_exp, small_exp, diff;
  logic [MW-1:0]   big_m, small_m, low_mask;
  logic            diff_far, sticky_near, wd_expired;

  // Exponent and fraction are contiguous, so one unsigned compare orders magnitudes.
  always_comb begin
    b_bigger    = b_reg[W-2:0] > a_reg[W-2:0];
    big_op      = b_bigger ? b_reg : a_reg;
    small_op    = b_bigger ? a_reg : b_reg;
    big_exp     = big_op[W-2:M];
    small_exp   = small_op[W-2:M];
    big_m       = {|big_exp, big_op[M-1:0]};
    small_m     = {|small_exp, small_op[M-1:0]};
    diff        = big_exp - small_exp;
    diff_far    = int'(diff) >= MW;
    low_mask    = ~({MW{1'b1}} << diff);
    sticky_near = |(small_m & low_mask);
    wd_expired  = wd_cnt == WD_LAST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    valid     = 1'b0;
    sh_enable = 1'b0;
    sh_load   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = CMP;
      end
      CMP: begin
        if (diff == '0 || diff_far) state_nx = DONE;
        else                        state_nx = LOAD;
      end
      LOAD: begin
        sh_enable = 1'b1;
        sh_load   = 1'b1;
        state_nx  = SHIFT;
      end
      SHIFT: begin
        sh_enable = 1'b1;
        if (sh_done || wd_expired) state_nx = DONE;
      end
      DONE: begin
        valid    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      small_unsh <= '0;
      diff_reg   <= '0;
      wd_cnt     <= '0;
      big_sign   <= 1'b0;
      small_sign <= 1'b0;
      exp_out    <= '0;
      big_mant   <= '0;
      small_mant <= '0;
      sticky     <= 1'b0;
      swapped    <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
          end
        end
        CMP: begin
          swapped    <= b_bigger;
          big_sign   <= big_op[W-1];
          small_sign <= small_op[W-1];
          exp_out    <= big_exp;
          big_mant   <= big_m;
          small_unsh <= small_m;
          diff_reg   <= diff;
          err        <= 1'b0;
          if (diff == '0) begin
            small_mant <= small_m;
            sticky     <= 1'b0;
          end else if (diff_far) begin
            small_mant <= '0;
            sticky     <= |small_m;
          end else begin
            small_mant <= '0;
            sticky     <= sticky_near;
          end
        end
        LOAD: wd_cnt <= '0;
        SHIFT: begin
          if (sh_done) begin
            small_mant <= sh_shifted;
          end else if (wd_expired) begin
            small_mant <= '0;
            sticky     <= 1'b1;
            err        <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sh_direction    = 1'b1;
  assign sh_no_of_shifts = diff_reg;
  assign sh_unshifted    = small_unsh;

endmodule
`default_nettype wire

// File: tb/tb_fp_align_sequencer.sv
`default_nettype none
// Bench for fp_align_sequencer: directed plan cases plus random operands
// compared with a magnitude/shift reference model and a behavioural shifter.
module tb_fp_align_sequencer;
  localparam int M = 23;
  localparam int E = 8;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy, valid, big_sign, small_sign, sticky, swapped, err;
  logic [7:0]  exp_out, sh_no_of_shifts;
  logic [23:0] big_mant, small_mant, sh_unshifted, sh_shifted;
  logic        sh_enable, sh_load, sh_direction, sh_done;

  int checks = 0;
  int errors = 0;
  bit stall = 0;

  fp_align_sequencer #(.Mantissa_Size(M), .Exponent_Size(E)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .valid(valid), .big_sign(big_sign), .small_sign(small_sign),
    .exp_out(exp_out), .big_mant(big_mant), .small_mant(small_mant),
    .sticky(sticky), .swapped(swapped), .err(err),
    .sh_enable(sh_enable), .sh_load(sh_load), .sh_direction(sh_direction),
    .sh_no_of_shifts(sh_no_of_shifts), .sh_unshifted(sh_unshifted),
    .sh_shifted(sh_shifted), .sh_done(sh_done)
  );

  always #5 clk = ~clk;

  // One-bit-per-cycle right shifter; stall suppresses its completion flag.
  logic [23:0] s_reg;
  logic [7:0]  s_cnt;
  logic        s_done;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg <= 0; s_cnt <= 0; s_done <= 0;
    end else if (sh_enable && sh_load) begin
      s_reg <= sh_unshifted; s_cnt <= sh_no_of_shifts; s_done <= 0;
    end else if (sh_enable) begin
      if (s_cnt != 0) begin
        s_reg <= s_reg >> 1; s_cnt <= s_cnt - 1;
      end else begin
        s_done <= !stall;
      end
    end else begin
      s_done <= 0;
    end
  end
  assign sh_shifted = s_reg;
  assign sh_done    = s_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: order by magnitude, shift the smaller significand by the exponent gap.
  task automatic model(input logic [31:0] x, input logic [31:0] y, input bit stl,
                       output bit sw, output bit bs, output bit ss, output int ex,
                       output longint bm, output longint sm, output bit st,
                       output bit er, output int lat);
    int ex_x, ex_y, es, d;
    longint mx, my, sml;
    ex_x = int'(x[30:23]);
    ex_y = int'(y[30:23]);
    mx = longint'(x[22:0]) + ((ex_x != 0) ? longint'(1) << 23 : 0);
    my = longint'(y[22:0]) + ((ex_y != 0) ? longint'(1) << 23 : 0);
    sw = (ex_y > ex_x) || (ex_y == ex_x && y[22:0] > x[22:0]);
    bs = sw ? y[31] : x[31];
    ss = sw ? x[31] : y[31];
    ex = sw ? ex_y : ex_x;
    es = sw ? ex_x : ex_y;
    bm = sw ? my : mx;
    sml = sw ? mx : my;
    d = ex - es;
    er = 0;
    if (d == 0) begin
      sm = sml; st = 0; lat = 1;
    end else if (d >= M + 1) begin
      sm = 0; st = (sml != 0); lat = 1;
    end else begin
      sm = sml >> d; st = (sml % (longint'(1) << d)) != 0; lat = 4 + d;
      if (stl) begin sm = 0; st = 1; er = 1; lat = M + 6; end
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input bit stl, input bit poke, input string tag);
    bit sw, bs, ss, st, er, got, seen_en;
    int ex, lat, n;
    longint bm, sm;
    model(x, y, stl, sw, bs, ss, ex, bm, sm, st, er, lat);
    stall = stl;
    @(negedge clk);
    start = 1; a = x; b = y;
    @(posedge clk);
    #1 start = 0;
    chk({tag, ":busy_rise"}, 64'(busy), 64'd1);
    n = 0; got = 0; seen_en = 0;
    while (!got && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (sh_enable) seen_en = 1;
      if (poke && n == 2) begin
        start = 1; a = $urandom; b = $urandom;
      end else begin
        start = 0;
      end
      if (valid) got = 1;
    end
    chk({tag, ":valid_seen"}, 64'(got), 64'd1);
    chk({tag, ":latency"}, 64'(n), 64'(lat));
    chk({tag, ":swapped"}, 64'(swapped), 64'(sw));
    chk({tag, ":big_sign"}, 64'(big_sign), 64'(bs));
    chk({tag, ":small_sign"}, 64'(small_sign), 64'(ss));
    chk({tag, ":exp_out"}, 64'(exp_out), 64'(ex));
    chk({tag, ":big_mant"}, 64'(big_mant), 64'(bm));
    chk({tag, ":small_mant"}, 64'(small_mant), 64'(sm));
    chk({tag, ":sticky"}, 64'(sticky), 64'(st));
    chk({tag, ":err"}, 64'(err), 64'(er));
    chk({tag, ":busy_at_valid"}, 64'(busy), 64'd1);
    if (lat == 1) chk({tag, ":no_sh_enable"}, 64'(seen_en), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, ":valid_pulse"}, 64'(valid), 64'd0);
    chk({tag, ":busy_fall"}, 64'(busy), 64'd0);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1 chk({tag, ":no_second_op"}, 64'(busy | valid), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] x, y;
    int ey;
    // Reset state
    #12;
    chk("rst:busy", 64'(busy), 0);
    chk("rst:valid", 64'(valid), 0);
    chk("rst:err_sticky_swapped", 64'({err, sticky, swapped}), 0);
    chk("rst:sh_ctl", 64'({sh_enable, sh_load, sh_direction}), 64'b001);
    chk("rst:data", 64'({exp_out, big_mant, small_mant}), 0);
    @(negedge clk) rst_n = 1;

    run_op(32'h40400000, 32'h3F800000, 0, 0, "plan_3_vs_1");
    run_op(32'h3F800000, 32'h41200000, 0, 0, "plan_swap_10");
    run_op(32'h4B800000, 32'h3F800001, 0, 0, "plan_far_bypass");
    run_op(32'h3F800000, 32'hBF800001, 0, 0, "plan_equal_exp");
    run_op(32'h40000000, 32'h3F800000, 1, 0, "plan_timeout");
    run_op(32'h40000000, 32'h3F800000, 0, 0, "plan_err_clear");
    run_op(32'h3F800000, 32'h3F800000, 0, 0, "full_tie");
    run_op(32'h41000000, 32'h3F800000, 0, 1, "start_while_busy");

    // Reset in the middle of SHIFT
    stall = 0;
    @(negedge clk);
    start = 1; a = 32'h42000000; b = 32'h3F800003;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(posedge clk);
    #1 chk("mid_rst:in_shift", 64'(sh_enable & ~sh_load), 64'd1);
    rst_n = 0;
    #1;
    chk("mid_rst:ctl", 64'({busy, valid, sh_enable, sh_load, err}), 0);
    chk("mid_rst:data", 64'({exp_out, big_mant, small_mant, sticky, swapped}), 0);
    repeat (3) @(posedge clk);
    #1 chk("mid_rst:no_valid", 64'(valid | busy), 0);
    @(negedge clk) rst_n = 1;
    run_op(32'h40400000, 32'h3F800000, 0, 0, "after_rst");

    // Random operands, mostly with nearby exponents to exercise the shifter
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      ey = int'(x[30:23]) + int'($urandom_range(0, 60)) - 30;
      if (ey < 0) ey = 0;
      if (ey > 255) ey = 255;
      y = {1'($urandom), 8'(ey), 23'($urandom)};
      if (i % 8 == 7) y = $urandom;
      run_op(x, y, (i % 13) == 5, 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
